// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder and its port controllers.
// No datapath here: state encoding, counter width, default latency.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } port_state_e;

    localparam int CNT_W           = 4;
    localparam int DEFAULT_LATENCY = 3;

endpackage

// File: rtl/mem_port_ctrl.sv
// Per-port request tracker: IDLE -> WAIT -> RESP -> IDLE, resp LATENCY cycles after first request cycle.
// No backpressure; a request dropped while waiting aborts and pulses abort_o.
module mem_port_ctrl
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    output logic resp_o,
    output logic abort_o
);

    port_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_o  = 1'b0;
        abort_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!req_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    abort_o = 1'b1;
                end else begin
                    // Counter reaching zero on this edge means the next cycle is the response.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                resp_o  = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word memory with independent instruction and data ports, byte-enable writes.
// Response LATENCY cycles after request; requesters must hold until resp, early drop flags proto_err.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY     = DEFAULT_LATENCY,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        proto_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] inst_idx, data_idx;
    logic          data_req, inst_abort, data_abort;
    logic          proto_err_q, proto_err_d;
    logic          unused_addr_bits;

    assign inst_idx = inst_addr[AW+1:2];
    assign data_idx = data_addr[AW+1:2];
    assign data_req = data_read | data_write;
    assign unused_addr_bits = ^{inst_addr[31:AW+2], inst_addr[1:0],
                                data_addr[31:AW+2], data_addr[1:0]};

    mem_port_ctrl #(.LATENCY(LATENCY)) u_inst_ctrl (
        .clk     (clk),
        .rst     (rst),
        .req_i   (inst_read),
        .resp_o  (inst_resp),
        .abort_o (inst_abort)
    );

    mem_port_ctrl #(.LATENCY(LATENCY)) u_data_ctrl (
        .clk     (clk),
        .rst     (rst),
        .req_i   (data_req),
        .resp_o  (data_resp),
        .abort_o (data_abort)
    );

    // Reads are combinational off the array, so a same-cycle write is not yet visible.
    assign inst_rdata = inst_resp ? mem_q[inst_idx] : '0;
    assign data_rdata = (data_resp && !data_write) ? mem_q[data_idx] : '0;

    always_ff @(posedge clk) begin
        if (!rst && data_resp && data_write) begin
            for (int b = 0; b < 4; b++) begin
                if (data_mbe[b]) begin
                    mem_q[data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    assign proto_err_d = proto_err_q | inst_abort | data_abort | (data_read & data_write);

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;

endmodule
